// File: rtl/temporal_pkg.sv
// Shared types for the temporal (race-logic) encoder: mode encoding and
// the comparison width helper used by every channel.
package temporal_pkg;

  typedef enum logic [1:0] {
    MODE_RISING  = 2'd0,
    MODE_FALLING = 2'd1,
    MODE_PULSE   = 2'd2,
    MODE_RSVD    = 2'd3
  } encoder_mode_t;

  // Wide enough for the value, the gamma time and value + pulse width without overflow.
  function automatic int unsigned cmp_width(int unsigned iw, int unsigned g, int unsigned pw);
    int unsigned w;
    int unsigned tw;
    int unsigned pwb;
    w   = iw;
    tw  = $clog2(g) + 1;
    pwb = $clog2(pw + 1);
    if (tw > w) w = tw;
    if (pwb > w) w = pwb;
    return w + 1;
  endfunction

endpackage

// File: rtl/unary_channel.sv
// One encoding channel: compares the gamma time against the captured value
// and registers the resulting temporal-coded bit.
module unary_channel
  import temporal_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned TW          = 4,
  parameter int unsigned G           = 16,
  parameter int unsigned PW          = 8
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic                   active_i,
  input  encoder_mode_t          mode_i,
  input  logic [INPUT_WIDTH-1:0] value_i,
  input  logic [TW-1:0]          t_i,
  output logic                   unary_o
);

  localparam int unsigned CW = cmp_width(INPUT_WIDTH, G, PW);

  logic [CW-1:0] t_ext;
  logic [CW-1:0] v_ext;
  logic [CW-1:0] v_end;
  logic          hit;
  logic          unary_d;
  logic          unary_q;

  // Values >= G never match a gamma time, so "no event" falls out of the compares.
  always_comb begin
    t_ext = CW'(t_i);
    v_ext = CW'(value_i);
    v_end = v_ext + CW'(PW);
    hit   = 1'b0;
    case (mode_i)
      MODE_RISING:  hit = (t_ext >= v_ext);
      MODE_FALLING: hit = (t_ext < v_ext);
      MODE_PULSE:   hit = (t_ext >= v_ext) && (t_ext < v_end);
      default:      hit = 1'b0;
    endcase
    unary_d = active_i && hit;
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      unary_q <= 1'b0;
    end else begin
      unary_q <= unary_d;
    end
  end

  assign unary_o = unary_q;

endmodule

// File: rtl/temporal_encoder.sv
// Multi-channel temporal encoder: free-running gamma counter, capture
// handshake at the last gamma slot, and per-channel unary encoders.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned INPUT_WIDTH       = 8,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8
) (
  input  logic                          aclk,
  input  logic                          grst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*INPUT_WIDTH-1:0] binary_input,
  input  logic [1:0]                    mode,
  output logic [NUM_CH-1:0]             unary_output,
  output logic                          gamma_start,
  output logic                          gamma_active
);

  localparam int unsigned     TW     = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [TW-1:0]   T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);

  logic [TW-1:0]                 t_q, t_d;
  logic                          armed_q;
  logic                          active_q, active_d;
  logic                          start_q, start_d;
  encoder_mode_t                 mode_q, mode_d;
  logic [NUM_CH*INPUT_WIDTH-1:0] val_q, val_d;
  logic                          capture;

  assign in_ready = (t_q == T_LAST);

  // armed_q blocks capture on the first edge after reset, so that gamma is always idle.
  always_comb begin
    capture  = in_valid && in_ready && armed_q;
    t_d      = in_ready ? '0 : t_q + TW'(1);
    start_d  = in_ready;
    val_d    = val_q;
    mode_d   = mode_q;
    active_d = active_q;
    if (capture) begin
      val_d    = binary_input;
      mode_d   = encoder_mode_t'(mode);
      active_d = 1'b1;
    end else if (in_ready) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      t_q      <= T_LAST;
      armed_q  <= 1'b0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      mode_q   <= MODE_RISING;
      val_q    <= '0;
    end else begin
      t_q      <= t_d;
      armed_q  <= 1'b1;
      active_q <= active_d;
      start_q  <= start_d;
      mode_q   <= mode_d;
      val_q    <= val_d;
    end
  end

  assign gamma_start  = start_q;
  assign gamma_active = active_q;

  // Channels register f(next value, next time) so each output lines up with its gamma time.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    unary_channel #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .TW          (TW),
      .G           (GAMMA_CYCLE_WIDTH),
      .PW          (PULSE_WIDTH)
    ) u_ch (
      .aclk     (aclk),
      .grst     (grst),
      .active_i (active_d),
      .mode_i   (mode_d),
      .value_i  (val_d[c*INPUT_WIDTH +: INPUT_WIDTH]),
      .t_i      (t_d),
      .unary_o  (unary_output[c])
    );
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (4 channels, 8-bit values, G=16, PW=8):
// per-cycle expected masks are written out by hand for each gamma.
module tb_temporal_encoder;

  logic        aclk;
  logic        grst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] binary_input;
  logic [1:0]  mode;
  logic [3:0]  unary_output;
  logic        gamma_start;
  logic        gamma_active;

  int unsigned checks = 0;
  int unsigned errors = 0;

  temporal_encoder #(
    .NUM_CH            (4),
    .INPUT_WIDTH       (8),
    .GAMMA_CYCLE_WIDTH (16),
    .PULSE_WIDTH       (8)
  ) dut (
    .aclk         (aclk),
    .grst         (grst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .binary_input (binary_input),
    .mode         (mode),
    .unary_output (unary_output),
    .gamma_start  (gamma_start),
    .gamma_active (gamma_active)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one gamma (t = 0..15) at negedges. Scrambles inputs at t=5 and
  // presents the next transaction at t=15.
  task automatic run_gamma(input string name,
                           input logic [15:0] m0, input logic [15:0] m1,
                           input logic [15:0] m2, input logic [15:0] m3,
                           input logic exp_act,
                           input logic [31:0] scr_vals, input logic [1:0] scr_mode,
                           input logic [31:0] nxt_vals, input logic [1:0] nxt_mode,
                           input logic nxt_valid);
    logic [3:0] exp_out;
    for (int t = 0; t < 16; t++) begin
      @(negedge aclk);
      exp_out = {m3[t], m2[t], m1[t], m0[t]};
      chk($sformatf("%s.out.t%0d", name, t), 32'(unary_output), 32'(exp_out));
      chk($sformatf("%s.start.t%0d", name, t), 32'(gamma_start), 32'(t == 0));
      chk($sformatf("%s.active.t%0d", name, t), 32'(gamma_active), 32'(exp_act));
      chk($sformatf("%s.ready.t%0d", name, t), 32'(in_ready), 32'(t == 15));
      if (t == 5) begin
        binary_input = scr_vals;
        mode         = scr_mode;
      end
      if (t == 15) begin
        binary_input = nxt_vals;
        mode         = nxt_mode;
        in_valid     = nxt_valid;
      end
    end
  endtask

  initial begin
    grst         = 1'b0;
    in_valid     = 1'b0;
    binary_input = '0;
    mode         = 2'd0;

    // Reset state
    @(negedge aclk);
    @(negedge aclk);
    chk("rst.ready",  32'(in_ready),     32'd1);
    chk("rst.out",    32'(unary_output), 32'd0);
    chk("rst.active", 32'(gamma_active), 32'd0);
    chk("rst.start",  32'(gamma_start),  32'd0);

    // Release with valid data already present: first gamma must still be idle.
    grst         = 1'b1;
    in_valid     = 1'b1;
    binary_input = 32'h1400_0801;
    mode         = 2'd0;
    run_gamma("idle0", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0,
              32'hFFFF_FFFF, 2'd2, 32'h1400_0801, 2'd0, 1'b1);

    // Rising {1,8,0,20}
    run_gamma("rise", 16'hFFFE, 16'hFF00, 16'hFFFF, 16'h0000, 1'b1,
              32'h0000_0000, 2'd1, 32'h1400_0801, 2'd1, 1'b1);
    // Falling {1,8,0,20}
    run_gamma("fall", 16'h0001, 16'h00FF, 16'h0000, 16'hFFFF, 1'b1,
              32'h0505_0505, 2'd0, 32'h100F_0A00, 2'd2, 1'b1);
    // Pulse {0,10,15,16}; next gamma has no capture
    run_gamma("pulse", 16'h00FF, 16'hFC00, 16'h8000, 16'h0000, 1'b1,
              32'h0000_0000, 2'd0, 32'h1400_0801, 2'd0, 1'b0);
    // No capture: idle gamma, then reserved mode
    run_gamma("novalid", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0,
              32'h0102_0304, 2'd0, 32'h1400_0801, 2'd3, 1'b1);
    run_gamma("rsvd", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1,
              32'h0000_0000, 2'd0, 32'h0907_0503, 2'd0, 1'b1);

    // Back-to-back captures with mid-gamma input changes
    run_gamma("b2b_rise", 16'hFFF8, 16'hFFE0, 16'hFF80, 16'hFE00, 1'b1,
              32'h0000_0000, 2'd1, 32'h0907_0503, 2'd1, 1'b1);
    run_gamma("b2b_fall", 16'h0007, 16'h001F, 16'h007F, 16'h01FF, 1'b1,
              32'hFFFF_FFFF, 2'd0, 32'h0E09_020C, 2'd2, 1'b1);
    run_gamma("b2b_pulse", 16'hF000, 16'h03FC, 16'hFE00, 16'hC000, 1'b1,
              32'h0000_0000, 2'd0, 32'h0303_0303, 2'd0, 1'b1);

    // Rising v=3, reset asserted at t=5
    for (int t = 0; t < 6; t++) begin
      @(negedge aclk);
      chk($sformatf("prerst.out.t%0d", t), 32'(unary_output), (t >= 3) ? 32'hF : 32'h0);
      chk($sformatf("prerst.active.t%0d", t), 32'(gamma_active), 32'd1);
    end
    grst = 1'b0;
    #1;
    chk("midrst.out",    32'(unary_output), 32'd0);
    chk("midrst.active", 32'(gamma_active), 32'd0);
    chk("midrst.start",  32'(gamma_start),  32'd0);
    chk("midrst.ready",  32'(in_ready),     32'd1);
    @(negedge aclk);
    chk("midrst.hold_out", 32'(unary_output), 32'd0);
    grst = 1'b1;
    run_gamma("postrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0,
              32'h0000_0000, 2'd0, 32'h0000_0000, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporal_encoder.md
TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent encoding channels (>=1).
REQ-002 Parameter INPUT_WIDTH, default 8: bits per channel binary value.
REQ-003 Parameter GAMMA_CYCLE_WIDTH (G), default 16: clock cycles per gamma cycle (>=2).
REQ-004 Parameter PULSE_WIDTH (PW), default 8: pulse length in cycles for pulse mode (>=1).
REQ-005 aclk  in  1  sole clock; all state on rising edge.
REQ-006 grst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 in_valid  in  1  binary_input and mode are valid for capture.
REQ-008 in_ready  out  1  capture slot open; high only at gamma time t = G-1.
REQ-009 binary_input  in  NUM_CH*INPUT_WIDTH  channel c at bits [c*INPUT_WIDTH +: INPUT_WIDTH].
REQ-010 mode  in  2  encoding mode for the captured gamma cycle (values per package).
REQ-011 unary_output  out  NUM_CH  one temporal-coded wire per channel.
REQ-012 gamma_start  out  1  one-cycle pulse at t = 0 of every gamma cycle.
REQ-013 gamma_active  out  1  current gamma carries captured data.

Function
REQ-014 Gamma time t SHALL count 0..G-1 free-running, wrapping G-1 -> 0 with no idle cycle.
REQ-015 Capture SHALL occur on the edge ending t = G-1 when in_valid && in_ready; values and mode hold for the whole following gamma.
REQ-016 Without capture at t = G-1, the following gamma SHALL have gamma_active = 0 and all unary_output = 0.
REQ-017 binary_input/mode changes outside t = G-1 SHALL have no effect on outputs.
REQ-018 Outputs are registered; for value v and gamma time t, unary_output[c] SHALL equal f(v, t) in the cycle whose gamma time is t.
REQ-019 MODE_RISING: f = 1 iff t >= v (stays high to end of gamma).
REQ-020 MODE_FALLING: f = 1 iff t < v.
REQ-021 MODE_PULSE: f = 1 iff v <= t < v + PW; truncated at t = G-1, no carry into next gamma.
REQ-022 v >= G SHALL mean "no event": rising/pulse stay 0, falling stays 1 the whole gamma.
REQ-023 Comparisons SHALL be zero-extended to max(INPUT_WIDTH, clog2(G)+1) bits; v + PW SHALL not overflow.
REQ-024 Reserved mode 2'b11: gamma_active = 1, all unary_output = 0.
REQ-025 Channels SHALL be fully independent; back-to-back captures every gamma SHALL be supported.

Reset
REQ-026 While grst = 0: t = G-1, unary_output = 0, gamma_active = 0, gamma_start = 0, latched values/mode = 0; in_ready = 1 but no capture occurs.
REQ-027 Reset assertion mid-gamma SHALL clear outputs asynchronously; first edge after release enters t = 0 with gamma_active = 0.

Structure
REQ-028 Package temporal_pkg SHALL hold the 2-bit enum encoder_mode_t (MODE_RISING=0, MODE_FALLING=1, MODE_PULSE=2, MODE_RSVD=3).
REQ-029 Gamma counter, capture handshake and gamma_start/gamma_active SHALL live in temporal_encoder.
REQ-030 Per-channel comparison and output register SHALL be sub-module unary_channel, instantiated NUM_CH times by generate.

Verification (NUM_CH=4, INPUT_WIDTH=8, G=16, PW=8)
REQ-031 Rising, values {1,8,0,20}: ch0 high t1..15, ch1 t8..15, ch2 t0..15, ch3 never.
REQ-032 Falling, values {1,8,0,20}: ch0 high t0 only, ch1 t0..7, ch2 never, ch3 t0..15.
REQ-033 Pulse, values {0,10,15,16}: ch0 high t0..7, ch1 t10..15, ch2 t15 only, ch3 never; all 0 at next t0.
REQ-034 in_valid low at t=15: next gamma gamma_active=0, outputs 0 for all 16 cycles; gamma_start still pulses at t0.
REQ-035 in_valid held high, inputs changed at t=5: no output change until next gamma; three back-to-back gammas each reflect values present at their t=15.
REQ-036 grst driven 0 at t=5 of a rising gamma with v=3: outputs drop to 0 immediately; after release, t0 gamma_active=0, in_ready high at t=15.
